// File: rtl/dac_out_stage.sv
// dac_out_stage: output stage between the ANC core and the I2S DAC transmitter.
// The core writes with one-cycle strobes and cannot be stalled, so samples are
// absorbed in a DEPTH-entry FIFO. A single output register presents them to the
// I2S TX with a valid/ready handshake.
// Optional feature macro: MUTE_RAMP_EN. When it is defined, each sample is scaled
// by a soft-mute gain ramp. When it is undefined, mute simply zeroes samples.
//
// Handshake: a sample transfers on a clock edge where out_valid_o & out_ready_i.
// While out_valid_o is high and out_ready_i is low, out_sample_o and out_valid_o
// are held stable. There is no back-pressure toward the ANC core.
module dac_out_stage #(
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 8,
  parameter int RAMP_SHIFT = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [DATA_W-1:0]          in_sample_i,
  input  logic                       in_valid_i,
  input  logic                       mute_i,
  input  logic                       clr_ovf_i,
  output logic [DATA_W-1:0]          out_sample_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic                       overflow_o,
  output logic [$clog2(DEPTH):0]     fill_level_o,
  output logic [1:0]                 dbg_state_o,
  output logic [RAMP_SHIFT:0]        dbg_gain_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [RAMP_SHIFT:0] G_MAX = (RAMP_SHIFT+1)'(1 << RAMP_SHIFT);

  localparam logic [1:0] S_MUTED   = 2'd0;
  localparam logic [1:0] S_RAMP_UP = 2'd1;
  localparam logic [1:0] S_UNITY   = 2'd2;
  localparam logic [1:0] S_RAMP_DN = 2'd3;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [DATA_W-1:0] out_sample_q;
  logic              out_valid_q;
  logic              overflow_q;

  logic              full, empty, pop, push, drop;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] scaled;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  // The output register reloads whenever it is empty or being drained this cycle.
  assign pop   = !empty && (!out_valid_q || out_ready_i);
  // A full FIFO still accepts a write when a pop frees a slot in the same cycle.
  assign push  = in_valid_i && (!full || pop);
  assign drop  = in_valid_i && full && !pop;
  assign head  = mem_q[rd_ptr_q];

  // FIFO storage; stale entries are harmless because the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_sample_i;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Output register: load on pop, drop valid after an accept with nothing behind it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
    end else if (pop) begin
      out_sample_q <= scaled;
      out_valid_q  <= 1'b1;
    end else if (out_ready_i) begin
      out_valid_q  <= 1'b0;
    end
  end

  // Sticky overflow; a drop in the same cycle as clr_ovf_i keeps it set.
  always_ff @(posedge clk_i) begin
    if (rst_i)          overflow_q <= 1'b0;
    else if (drop)      overflow_q <= 1'b1;
    else if (clr_ovf_i) overflow_q <= 1'b0;
  end

`ifdef MUTE_RAMP_EN
  localparam int PW = DATA_W + RAMP_SHIFT + 1;

  logic [1:0]          state_q, state_d;
  logic [RAMP_SHIFT:0] gain_q, gain_d;
  logic                step_up, step_dn;
  logic signed [PW-1:0] head_ext, gain_ext, prod;

  // Scale the head sample by the gain in force before this pop updates it.
  assign head_ext = {{(PW-DATA_W){head[DATA_W-1]}}, head};
  assign gain_ext = {{(PW-RAMP_SHIFT-1){1'b0}}, gain_q};
  assign prod     = head_ext * gain_ext;
  assign scaled   = prod[DATA_W+RAMP_SHIFT-1:RAMP_SHIFT];

  // Gain ramp: one step per pop; mute direction decides up or down.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    step_up = 1'b0;
    step_dn = 1'b0;
    case (state_q)
      S_MUTED:   step_up = !mute_i;
      S_RAMP_UP: begin step_up = !mute_i; step_dn = mute_i; end
      S_UNITY:   step_dn = mute_i;
      S_RAMP_DN: begin step_up = !mute_i; step_dn = mute_i; end
      default:   begin state_d = S_MUTED; gain_d = '0; end
    endcase
    if (pop && step_up) begin
      gain_d  = gain_q + 1'b1;
      state_d = (gain_d == G_MAX) ? S_UNITY : S_RAMP_UP;
    end else if (pop && step_dn) begin
      gain_d  = gain_q - 1'b1;
      state_d = (gain_d == '0) ? S_MUTED : S_RAMP_DN;
    end
  end

  // Gain state registers; reset starts fully muted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_MUTED;
      gain_q  <= '0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
    end
  end

  assign dbg_state_o = state_q;
  assign dbg_gain_o  = gain_q;
`else
  // Hard mute: mute is sampled at the moment of the load.
  assign scaled      = mute_i ? '0 : head;
  assign dbg_state_o = S_UNITY;
  assign dbg_gain_o  = G_MAX;
`endif

  assign out_sample_o = out_sample_q;
  assign out_valid_o  = out_valid_q;
  assign overflow_o   = overflow_q;
  assign fill_level_o = count_q;

endmodule

// File: tb/tb_dac_out_stage.sv
// tb_dac_out_stage: directed bench for dac_out_stage with a scoreboard queue.
// Expected samples are computed from a gain model when each write is driven and
// compared when the DUT hands the sample to the I2S side.
module tb_dac_out_stage;
  localparam int DATA_W     = 16;
  localparam int DEPTH      = 8;
  localparam int RAMP_SHIFT = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] in_sample = '0;
  logic              in_valid = 1'b0;
  logic              mute = 1'b0;
  logic              clr_ovf = 1'b0;
  logic [DATA_W-1:0] out_sample;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              overflow;
  logic [$clog2(DEPTH):0] fill_level;
  logic [1:0]        dbg_state;
  logic [RAMP_SHIFT:0] dbg_gain;

  logic [DATA_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int g_model = 0;
  logic [DATA_W-1:0] hold_val;

  dac_out_stage #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RAMP_SHIFT(RAMP_SHIFT)) dut (
    .clk_i(clk), .rst_i(rst), .in_sample_i(in_sample), .in_valid_i(in_valid),
    .mute_i(mute), .clr_ovf_i(clr_ovf), .out_sample_o(out_sample),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .overflow_o(overflow),
    .fill_level_o(fill_level), .dbg_state_o(dbg_state), .dbg_gain_o(dbg_gain)
  );

  // Clock and global time limit.
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not reach its summary");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected output for a sample loaded with the current mute level.
  task automatic push_exp(input logic [DATA_W-1:0] s);
    int sv;
    int p;
    logic [DATA_W-1:0] e;
`ifdef MUTE_RAMP_EN
    sv = $signed(s);
    p  = (sv * g_model) >>> RAMP_SHIFT;
    e  = p[DATA_W-1:0];
    if (!mute && g_model < (1 << RAMP_SHIFT)) g_model++;
    else if (mute && g_model > 0) g_model--;
`else
    sv = 0;
    p  = 0;
    e  = mute ? '0 : s;
`endif
    exp_q.push_back(e);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write(input logic [DATA_W-1:0] s, input bit accept);
    in_sample = s;
    in_valid  = 1'b1;
    if (accept) push_exp(s);
    step();
    in_valid  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((out_valid || fill_level != 0) && n < 100) begin
      step();
      n++;
    end
    chk("drain_in_time", 32'(n < 100), 32'd1);
  endtask

  // Scoreboard: compare each accepted output against the queue head.
  always @(negedge clk) begin : mon
    logic [DATA_W-1:0] e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_output: got %0h with empty expected queue", out_sample);
      end else begin
        e = exp_q.pop_front();
        chk("out_sample", 32'(out_sample), 32'(e));
      end
    end
  end

  initial begin
    // Reset state
    step(2);
    chk("rst_fill", 32'(fill_level), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_sample", 32'(out_sample), 32'd0);
`ifdef MUTE_RAMP_EN
    chk("rst_gain", 32'(dbg_gain), 32'd0);
`endif
    rst = 1'b0;
    step();

    // 1: one write every 4 cycles, first output at N+2, valid drops after accept
    for (int i = 0; i < 20; i++) begin
      write(16'h1000, 1'b1);
      if (i == 0) begin
        chk("lat_n1_idle", 32'(out_valid), 32'd0);
        step();
        chk("lat_n2_valid", 32'(out_valid), 32'd1);
        step();
        chk("valid_drops", 32'(out_valid), 32'd0);
        step();
      end else begin
        step(3);
      end
    end
    wait_idle();

    // 2: back-pressure; 8 writes fill register + 7 entries, 9th fills, 10th drops
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) write(16'h2000 + 16'(i), 1'b1);
    chk("bp_fill7", 32'(fill_level), 32'd7);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_ovf0", 32'(overflow), 32'd0);
    hold_val = exp_q[0];
    chk("bp_hold", 32'(out_sample), 32'(hold_val));
    write(16'h2008, 1'b1);
    chk("bp_fill8", 32'(fill_level), 32'd8);
    chk("bp_ovf_still0", 32'(overflow), 32'd0);
    write(16'h2009, 1'b0);
    chk("drop_fill8", 32'(fill_level), 32'd8);
    chk("drop_ovf1", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("clr_ovf", 32'(overflow), 32'd0);

    // 3: full FIFO, write and pop in the same cycle
    out_ready = 1'b1;
    write(16'h200A, 1'b1);
    chk("full_wr_pop_fill", 32'(fill_level), 32'd8);
    chk("full_wr_pop_ovf", 32'(overflow), 32'd0);
    wait_idle();

    // 4: extremes at unity gain, then 3 muted pops and recovery
    write(16'h7FFF, 1'b1); step(3);
    write(16'h8000, 1'b1); step(3);
    mute = 1'b1;
    repeat (3) begin write(16'h7FFF, 1'b1); step(3); end
    mute = 1'b0;
    repeat (4) begin write(16'h7FFF, 1'b1); step(3); end
    wait_idle();

    // 5: stall with a valid output
    out_ready = 1'b0;
    write(16'h1234, 1'b1);
    step();
    hold_val = exp_q[0];
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_sample", 32'(out_sample), 32'(hold_val));
      chk("stall_fill", 32'(fill_level), 32'd0);
`ifdef MUTE_RAMP_EN
      chk("stall_gain", 32'(dbg_gain), 32'(g_model));
`endif
      step();
    end
    out_ready = 1'b1;
    wait_idle();

    // 6: reset with data in flight
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) write(16'h0100 * 16'(i + 1), 1'b1);
    chk("pre_rst_fill5", 32'(fill_level), 32'd5);
    rst = 1'b1;
    step();
    chk("mid_rst_fill", 32'(fill_level), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
`ifdef MUTE_RAMP_EN
    chk("mid_rst_gain", 32'(dbg_gain), 32'd0);
`endif
    rst = 1'b0;
    exp_q.delete();
    g_model = 0;
    out_ready = 1'b1;
    step();
    write(16'h4000, 1'b1);
    step(3);
    wait_idle();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
